// File: rtl/delay_line_tapped_pkg.sv
// Shared helpers for the tapped delay line.
// Contents:
//   tap_width() - width of the tap-select field for a given depth
//   cnt_width() - width of a fill counter that can hold 0..depth
//   clamp_tap() - limits a tap request to the last existing stage
package delay_line_tapped_pkg;

  function automatic int tap_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // A non-power-of-two depth leaves select codes with no stage behind them;
  // those codes read the oldest stage.
  function automatic int unsigned clamp_tap(input int unsigned sel,
                                            input int unsigned depth);
    return (sel >= depth) ? depth - 1 : sel;
  endfunction

endpackage

// File: rtl/delay_line_tapped_if.sv
// Signal bundle between a sample source and the tapped delay line.
//   master : drives en, flush, sig_in, tap_sel; observes the delayed outputs
//   slave  : the delay line itself
interface delay_line_tapped_if
  import delay_line_tapped_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int DEPTH = 2
);
  localparam int TAP_W = tap_width(DEPTH);
  localparam int CNT_W = cnt_width(DEPTH);

  logic             en;
  logic             flush;
  logic [WIDTH-1:0] sig_in;
  logic [TAP_W-1:0] tap_sel;
  logic [WIDTH-1:0] tap_out;
  logic             tap_valid;
  logic [WIDTH-1:0] last_out;
  logic [WIDTH-1:0] rise_out;
  logic [WIDTH-1:0] fall_out;
  logic [CNT_W-1:0] fill_count;

  modport master (
    output en, flush, sig_in, tap_sel,
    input  tap_out, tap_valid, last_out, rise_out, fall_out, fill_count
  );

  modport slave (
    input  en, flush, sig_in, tap_sel,
    output tap_out, tap_valid, last_out, rise_out, fall_out, fill_count
  );

endinterface

// File: rtl/delay_line_tapped_delay_stage.sv
// One WIDTH-bit stage of the delay line.
// Ports:
//   clk, sys_rst : clock and synchronous active-high reset
//   en_i         : load d_i when high, hold when low
//   flush_i      : load RESET_VAL (wins over en_i)
//   d_i / q_o    : stage input / registered output
module delay_line_tapped_delay_stage #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             sys_rst,
  input  logic             en_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (flush_i)   q_d = RESET_VAL;
    else if (en_i) q_d = d_i;
  end

  always_ff @(posedge clk) begin
    if (sys_rst) q_q <= RESET_VAL;
    else         q_q <= q_d;
  end

  assign q_o = q_q;

endmodule

// File: rtl/delay_line_tapped.sv
// Multi-bit shift-register delay line with a runtime-selectable tap, clock
// enable, flush, fill tracking and per-bit edge strobes.
// Ports:
//   clk, sys_rst : single clock, synchronous active-high reset
//   bus (slave)  : en, flush, sig_in, tap_sel in;
//                  tap_out, tap_valid, last_out, rise_out, fall_out,
//                  fill_count out (all registered-only, no path from sig_in)
module delay_line_tapped
  import delay_line_tapped_pkg::*;
#(
  parameter int               WIDTH     = 1,
  parameter int               DEPTH     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                clk,
  input  logic                sys_rst,
  delay_line_tapped_if.slave  bus
);

  localparam int TAP_W = tap_width(DEPTH);
  localparam int CNT_W = cnt_width(DEPTH);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_W'(DEPTH)) ? c : c + CNT_W'(1);
  endfunction

  logic [WIDTH-1:0] stage_in [DEPTH];
  logic [WIDTH-1:0] stage_q  [DEPTH];

  assign stage_in[0] = bus.sig_in;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    if (k > 0) begin : g_chain
      assign stage_in[k] = stage_q[k-1];
    end
    delay_line_tapped_delay_stage #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_stage (
      .clk     (clk),
      .sys_rst (sys_rst),
      .en_i    (bus.en),
      .flush_i (bus.flush),
      .d_i     (stage_in[k]),
      .q_o     (stage_q[k])
    );
  end

  logic [CNT_W-1:0] fill_q, fill_d;

  always_comb begin
    fill_d = fill_q;
    if (bus.flush)   fill_d = '0;
    else if (bus.en) fill_d = sat_inc(fill_q);
  end

  always_ff @(posedge clk) begin
    if (sys_rst) fill_q <= '0;
    else         fill_q <= fill_d;
  end

  logic [TAP_W-1:0] eff_tap;
  logic             edge_ok;

  assign eff_tap = TAP_W'(clamp_tap(32'(bus.tap_sel), 32'(DEPTH)));

  // Until two real samples are in, stage[1] still holds RESET_VAL and any
  // difference against it would be a false edge.
  assign edge_ok = (fill_q >= CNT_W'(2));

  assign bus.tap_out    = stage_q[eff_tap];
  assign bus.tap_valid  = (fill_q > CNT_W'(eff_tap));
  assign bus.last_out   = stage_q[DEPTH-1];
  assign bus.rise_out   = edge_ok ? (stage_q[0] & ~stage_q[1]) : '0;
  assign bus.fall_out   = edge_ok ? (~stage_q[0] & stage_q[1]) : '0;
  assign bus.fill_count = fill_q;

endmodule

// File: tb/tb_delay_line_tapped.sv
// Bench for delay_line_tapped: three configurations sharing one clock/reset.
//   A: WIDTH=1 DEPTH=2 RESET_VAL=0
//   B: WIDTH=8 DEPTH=5 RESET_VAL=0
//   C: WIDTH=8 DEPTH=5 RESET_VAL=FF
module tb_delay_line_tapped;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  delay_line_tapped_if #(.WIDTH(1), .DEPTH(2)) ifa ();
  delay_line_tapped_if #(.WIDTH(8), .DEPTH(5)) ifb ();
  delay_line_tapped_if #(.WIDTH(8), .DEPTH(5)) ifc ();

  delay_line_tapped #(.WIDTH(1), .DEPTH(2), .RESET_VAL(1'b0)) dut_a (
    .clk(clk), .sys_rst(rst), .bus(ifa));
  delay_line_tapped #(.WIDTH(8), .DEPTH(5), .RESET_VAL(8'h00)) dut_b (
    .clk(clk), .sys_rst(rst), .bus(ifb));
  delay_line_tapped #(.WIDTH(8), .DEPTH(5), .RESET_VAL(8'hFF)) dut_c (
    .clk(clk), .sys_rst(rst), .bus(ifc));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    ifa.en = 0; ifa.flush = 0; ifa.sig_in = '0; ifa.tap_sel = '0;
    ifb.en = 0; ifb.flush = 0; ifb.sig_in = '0; ifb.tap_sel = '0;
    ifc.en = 0; ifc.flush = 0; ifc.sig_in = '0; ifc.tap_sel = '0;
  endtask

  task automatic do_reset();
    idle_all();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ifa.en = 1; ifa.sig_in = 1'b1; ifa.tap_sel = 1'b1;
    ifb.en = 1; ifb.sig_in = 8'h5A; ifb.tap_sel = 3'd3;
    ifc.en = 1; ifc.sig_in = 8'h00; ifc.tap_sel = 3'd0;
    tick();
    n_tests++; if (ifa.tap_out !== 1'b0) begin n_fail++; $display("FAIL rst A tap_out got %h exp 0", ifa.tap_out); end
    n_tests++; if (ifa.last_out !== 1'b0) begin n_fail++; $display("FAIL rst A last_out got %h exp 0", ifa.last_out); end
    n_tests++; if (ifa.rise_out !== 1'b0) begin n_fail++; $display("FAIL rst A rise_out got %h exp 0", ifa.rise_out); end
    n_tests++; if (ifa.tap_valid !== 1'b0) begin n_fail++; $display("FAIL rst A tap_valid got %b exp 0", ifa.tap_valid); end
    n_tests++; if (ifb.tap_out !== 8'h00) begin n_fail++; $display("FAIL rst B tap_out got %h exp 00", ifb.tap_out); end
    n_tests++; if (ifb.last_out !== 8'h00) begin n_fail++; $display("FAIL rst B last_out got %h exp 00", ifb.last_out); end
    n_tests++; if (ifb.fill_count !== 3'd0) begin n_fail++; $display("FAIL rst B fill got %0d exp 0", ifb.fill_count); end
    n_tests++; if (ifb.fall_out !== 8'h00) begin n_fail++; $display("FAIL rst B fall_out got %h exp 00", ifb.fall_out); end
    n_tests++; if (ifc.tap_out !== 8'hFF) begin n_fail++; $display("FAIL rst C tap_out got %h exp FF", ifc.tap_out); end
    n_tests++; if (ifc.last_out !== 8'hFF) begin n_fail++; $display("FAIL rst C last_out got %h exp FF", ifc.last_out); end
    n_tests++; if (ifc.fill_count !== 3'd0) begin n_fail++; $display("FAIL rst C fill got %0d exp 0", ifc.fill_count); end
    n_tests++; if (ifc.tap_valid !== 1'b0) begin n_fail++; $display("FAIL rst C tap_valid got %b exp 0", ifc.tap_valid); end
    rst = 1'b0;
    idle_all();
  endtask

  // Single-bit step 0->1 at the 5th enable through DEPTH=2.
  task automatic test_rise_w1();
    logic q[$];
    logic exp_last;
    do_reset();
    q.push_back(1'b0);
    ifa.tap_sel = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      ifa.en = 1'b1;
      ifa.sig_in = (k >= 5);
      q.push_back(ifa.sig_in);
      tick();
      exp_last = q.pop_front();
      n_tests++; if (ifa.last_out !== exp_last) begin n_fail++; $display("FAIL w1 last_out k=%0d got %b exp %b", k, ifa.last_out, exp_last); end
      n_tests++; if (ifa.rise_out !== 1'(k == 5)) begin n_fail++; $display("FAIL w1 rise_out k=%0d got %b exp %b", k, ifa.rise_out, k == 5); end
      n_tests++; if (ifa.fall_out !== 1'b0) begin n_fail++; $display("FAIL w1 fall_out k=%0d got %b exp 0", k, ifa.fall_out); end
      n_tests++; if (ifa.fill_count !== 2'((k < 2) ? k : 2)) begin n_fail++; $display("FAIL w1 fill k=%0d got %0d", k, ifa.fill_count); end
    end
    idle_all();
  endtask

  // Counter through tap 3; also checks fill saturation at 5.
  task automatic test_tap_counter();
    logic [7:0] q[$];
    logic [7:0] exp_tap;
    do_reset();
    ifb.tap_sel = 3'd3;
    for (int k = 1; k <= 12; k++) begin
      ifb.en = 1'b1;
      ifb.sig_in = 8'(k + 250);
      q.push_back(ifb.sig_in);
      tick();
      exp_tap = (q.size() == 4) ? q.pop_front() : 8'h00;
      n_tests++; if (ifb.tap_out !== exp_tap) begin n_fail++; $display("FAIL cnt tap_out k=%0d got %h exp %h", k, ifb.tap_out, exp_tap); end
      n_tests++; if (ifb.tap_valid !== 1'(k >= 4)) begin n_fail++; $display("FAIL cnt tap_valid k=%0d got %b exp %b", k, ifb.tap_valid, k >= 4); end
      n_tests++; if (ifb.fill_count !== 3'((k < 5) ? k : 5)) begin n_fail++; $display("FAIL cnt fill k=%0d got %0d", k, ifb.fill_count); end
    end
    idle_all();
  endtask

  // tap_sel=7 on DEPTH=5 reads stage 4; tap changes leave contents intact.
  task automatic test_tap_clamp();
    logic [7:0] q[$];
    logic [7:0] exp_tap, popped, newest;
    do_reset();
    popped = 8'h00;
    newest = 8'h00;
    ifb.tap_sel = 3'd7;
    for (int k = 1; k <= 8; k++) begin
      ifb.en = 1'b1;
      ifb.sig_in = 8'(8'hC0 + k * 3);
      newest = ifb.sig_in;
      q.push_back(ifb.sig_in);
      tick();
      exp_tap = 8'h00;
      if (q.size() == 5) begin popped = q.pop_front(); exp_tap = popped; end
      n_tests++; if (ifb.tap_out !== exp_tap) begin n_fail++; $display("FAIL clamp tap_out k=%0d got %h exp %h", k, ifb.tap_out, exp_tap); end
      n_tests++; if (ifb.tap_valid !== 1'(k >= 5)) begin n_fail++; $display("FAIL clamp tap_valid k=%0d got %b exp %b", k, ifb.tap_valid, k >= 5); end
    end
    ifb.en = 1'b0;
    ifb.tap_sel = 3'd0;
    tick();
    n_tests++; if (ifb.tap_out !== newest) begin n_fail++; $display("FAIL clamp tap0 got %h exp %h", ifb.tap_out, newest); end
    ifb.tap_sel = 3'd4;
    tick();
    n_tests++; if (ifb.tap_out !== popped) begin n_fail++; $display("FAIL clamp tap4 got %h exp %h", ifb.tap_out, popped); end
    ifb.tap_sel = 3'd7;
    for (int k = 9; k <= 10; k++) begin
      ifb.en = 1'b1;
      ifb.sig_in = 8'(8'hC0 + k * 3);
      q.push_back(ifb.sig_in);
      tick();
      exp_tap = q.pop_front();
      n_tests++; if (ifb.tap_out !== exp_tap) begin n_fail++; $display("FAIL clamp resume k=%0d got %h exp %h", k, ifb.tap_out, exp_tap); end
    end
    idle_all();
  endtask

  // en pattern 1,0,0,1: B and C are never captured.
  task automatic test_enable_gaps();
    logic [7:0] exp_q[$];
    logic [7:0] prev, exp_tap;
    logic       en_pat [4];
    logic [7:0] sig_pat [4];
    en_pat  = '{1'b1, 1'b0, 1'b0, 1'b1};
    sig_pat = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    do_reset();
    prev = 8'h00;
    ifb.tap_sel = 3'd0;
    for (int k = 0; k < 4; k++) begin
      ifb.en = en_pat[k];
      ifb.sig_in = sig_pat[k];
      if (en_pat[k]) prev = sig_pat[k];
      exp_q.push_back(prev);
      tick();
      exp_tap = exp_q.pop_front();
      n_tests++; if (ifb.tap_out !== exp_tap) begin n_fail++; $display("FAIL gaps stage0 k=%0d got %h exp %h", k, ifb.tap_out, exp_tap); end
    end
    ifb.en = 1'b0;
    ifb.tap_sel = 3'd1;
    tick();
    n_tests++; if (ifb.fill_count !== 3'd2) begin n_fail++; $display("FAIL gaps fill got %0d exp 2", ifb.fill_count); end
    n_tests++; if (ifb.tap_out !== 8'hA1) begin n_fail++; $display("FAIL gaps stage1 got %h exp a1", ifb.tap_out); end
    n_tests++; if (ifb.tap_valid !== 1'b1) begin n_fail++; $display("FAIL gaps valid1 got %b exp 1", ifb.tap_valid); end
    ifb.tap_sel = 3'd2;
    tick();
    n_tests++; if (ifb.tap_valid !== 1'b0) begin n_fail++; $display("FAIL gaps valid2 got %b exp 0", ifb.tap_valid); end
    idle_all();
  endtask

  // mode 0: flush, 1: sys_rst, 2: both -- all with en=1 on a full line.
  task automatic test_flush();
    for (int mode = 0; mode < 3; mode++) begin
      do_reset();
      ifb.tap_sel = 3'd2;
      for (int k = 1; k <= 6; k++) begin
        ifb.en = 1'b1;
        ifb.sig_in = 8'(8'h40 + k);
        tick();
      end
      n_tests++; if (ifb.fill_count !== 3'd5) begin n_fail++; $display("FAIL flush m%0d pre fill got %0d exp 5", mode, ifb.fill_count); end
      ifb.flush = (mode != 1);
      rst = (mode != 0);
      ifb.sig_in = 8'hAA;
      tick();
      ifb.flush = 1'b0;
      rst = 1'b0;
      n_tests++; if (ifb.tap_out !== 8'h00) begin n_fail++; $display("FAIL flush m%0d tap_out got %h exp 00", mode, ifb.tap_out); end
      n_tests++; if (ifb.last_out !== 8'h00) begin n_fail++; $display("FAIL flush m%0d last_out got %h exp 00", mode, ifb.last_out); end
      n_tests++; if (ifb.fill_count !== 3'd0) begin n_fail++; $display("FAIL flush m%0d fill got %0d exp 0", mode, ifb.fill_count); end
      n_tests++; if (ifb.tap_valid !== 1'b0) begin n_fail++; $display("FAIL flush m%0d tap_valid got %b exp 0", mode, ifb.tap_valid); end
      n_tests++; if ({ifb.rise_out, ifb.fall_out} !== 16'h0000) begin n_fail++; $display("FAIL flush m%0d edges got %h exp 0000", mode, {ifb.rise_out, ifb.fall_out}); end
      ifb.sig_in = 8'h55;
      ifb.tap_sel = 3'd0;
      tick();
      n_tests++; if (ifb.tap_out !== 8'h55) begin n_fail++; $display("FAIL flush m%0d restart tap_out got %h exp 55", mode, ifb.tap_out); end
      n_tests++; if (ifb.rise_out !== 8'h00) begin n_fail++; $display("FAIL flush m%0d gated rise got %h exp 00", mode, ifb.rise_out); end
      n_tests++; if (ifb.fill_count !== 3'd1) begin n_fail++; $display("FAIL flush m%0d restart fill got %0d exp 1", mode, ifb.fill_count); end
    end
    idle_all();
  endtask

  // RESET_VAL=FF: first sample 00 must not report a fall.
  task automatic test_fall_rv();
    logic [15:0] exp_q[$];
    logic [15:0] exp_rf;
    logic [7:0]  samp [3];
    samp = '{8'h00, 8'hFF, 8'h00};
    do_reset();
    exp_q.push_back({8'h00, 8'h00});
    exp_q.push_back({8'hFF, 8'h00});
    exp_q.push_back({8'h00, 8'hFF});
    for (int k = 0; k < 3; k++) begin
      ifc.en = 1'b1;
      ifc.sig_in = samp[k];
      tick();
      exp_rf = exp_q.pop_front();
      n_tests++; if ({ifc.rise_out, ifc.fall_out} !== exp_rf) begin n_fail++; $display("FAIL rv edges k=%0d got %h exp %h", k, {ifc.rise_out, ifc.fall_out}, exp_rf); end
    end
    n_tests++; if (ifc.last_out !== 8'hFF) begin n_fail++; $display("FAIL rv last_out got %h exp ff", ifc.last_out); end
    idle_all();
  endtask

  // Random en/flush/tap against a sample-history model.
  task automatic test_back_to_back();
    logic [7:0] hist[$];
    logic [7:0] exp_tap, exp_rise, exp_fall;
    int         eff;
    do_reset();
    for (int c = 0; c < 80; c++) begin
      ifb.en = ($urandom_range(0, 3) != 0);
      ifb.flush = ($urandom_range(0, 19) == 0);
      ifb.tap_sel = 3'($urandom_range(0, 7));
      ifb.sig_in = 8'($urandom);
      if (ifb.flush) hist.delete();
      else if (ifb.en) begin
        hist.push_front(ifb.sig_in);
        if (hist.size() > 5) void'(hist.pop_back());
      end
      tick();
      eff = (ifb.tap_sel > 3'd4) ? 4 : int'(ifb.tap_sel);
      exp_tap  = (hist.size() > eff) ? hist[eff] : 8'h00;
      exp_rise = (hist.size() >= 2) ? (hist[0] & ~hist[1]) : 8'h00;
      exp_fall = (hist.size() >= 2) ? (~hist[0] & hist[1]) : 8'h00;
      n_tests++; if (ifb.tap_out !== exp_tap) begin n_fail++; $display("FAIL b2b tap_out c=%0d got %h exp %h", c, ifb.tap_out, exp_tap); end
      n_tests++; if (ifb.tap_valid !== 1'(hist.size() > eff)) begin n_fail++; $display("FAIL b2b tap_valid c=%0d got %b", c, ifb.tap_valid); end
      n_tests++; if (ifb.fill_count !== 3'(hist.size())) begin n_fail++; $display("FAIL b2b fill c=%0d got %0d exp %0d", c, ifb.fill_count, hist.size()); end
      n_tests++; if ({ifb.rise_out, ifb.fall_out} !== {exp_rise, exp_fall}) begin n_fail++; $display("FAIL b2b edges c=%0d got %h exp %h", c, {ifb.rise_out, ifb.fall_out}, {exp_rise, exp_fall}); end
    end
    idle_all();
  endtask

  initial begin
    rst = 1'b1;
    idle_all();
    tick();
    test_reset();
    test_rise_w1();
    test_tap_counter();
    test_tap_clamp();
    test_enable_gaps();
    test_flush();
    test_fall_rv();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
